// File: rtl/rx_fifo_fct.sv
// SpaceWire receive buffer: stores incoming N-Chars for host readout and
// manages the flow-control credit that paces the far-end transmitter.
module rx_fifo_fct #(
  parameter int DATA_WIDTH  = 9,
  parameter int ADDR_WIDTH  = 6,
  parameter int CREDIT_MAX  = 56,
  parameter int CREDIT_STEP = 8
) (
  input  logic                  posedge_clk,
  input  logic                  rx_resetn,
  input  logic                  link_run,
  input  logic [DATA_WIDTH-1:0] rx_data_flag,
  input  logic                  rx_buffer_write,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  fct_send_req,
  input  logic                  fct_sent,
  output logic                  credit_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(CREDIT_MAX + 1);
  localparam int SW    = ADDR_WIDTH + 3;

  localparam logic [SW-1:0] STEP_W  = SW'(CREDIT_STEP);
  localparam logic [SW-1:0] MAX_W   = SW'(CREDIT_MAX);
  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  req_q, req_d;
  logic                  cerr_q, cerr_d;

  logic          empty_w, full_w;
  logic          rd_acc, wr_acc;
  logic          credit_inc, credit_dec;
  logic [SW-1:0] credit_sum;

  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == (ADDR_WIDTH+1)'(DEPTH));

  // A write at full is only accepted when a read frees the slot in the same edge.
  assign rd_acc = rd_en && !empty_w;
  assign wr_acc = rx_buffer_write && (!full_w || rd_acc);

  assign credit_inc = fct_sent && req_q;
  assign credit_dec = wr_acc && (credit_q != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    if (wr_acc && !rd_acc) begin
      level_d = level_q + (ADDR_WIDTH+1)'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - (ADDR_WIDTH+1)'(1);
    end
  end

  always_comb begin
    credit_sum = SW'(credit_q) + (credit_inc ? STEP_W : '0) - (credit_dec ? SW'(1) : '0);
    credit_d   = credit_sum[CW-1:0];
    cerr_d     = cerr_q || (rx_buffer_write && (credit_q == '0));
    // Request only when another grant stays within the credit cap and the
    // post-edge free space still covers everything already promised plus one step.
    req_d      = ((credit_sum + STEP_W) <= MAX_W) &&
                 ((SW'(level_d) + credit_sum + STEP_W) <= DEPTH_W);
    if (!link_run) begin
      credit_d = '0;
      cerr_d   = 1'b0;
      req_d    = 1'b0;
    end
  end

  always_ff @(posedge posedge_clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= rx_data_flag;
    end
  end

  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      credit_q  <= '0;
      req_q     <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      credit_q  <= credit_d;
      req_q     <= req_d;
      cerr_q    <= cerr_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign level        = level_q;
  assign fct_send_req = req_q;
  assign credit_error = cerr_q;

endmodule

// File: tb/tb_rx_fifo_fct.sv
// Bench for rx_fifo_fct: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rx_fifo_fct;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       link_run = 1'b0;
  logic [8:0] din = '0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       fct_sent = 1'b0;
  logic [8:0] rd_data;
  logic       empty, full, req, cerr;
  logic [6:0] level;

  int pass_cnt = 0;
  int total_cnt = 0;

  rx_fifo_fct #(
    .DATA_WIDTH (9),
    .ADDR_WIDTH (6),
    .CREDIT_MAX (56),
    .CREDIT_STEP(8)
  ) dut (
    .posedge_clk    (clk),
    .rx_resetn      (rst_n),
    .link_run       (link_run),
    .rx_data_flag   (din),
    .rx_buffer_write(wr),
    .rd_en          (rd),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .level          (level),
    .fct_send_req   (req),
    .fct_sent       (fct_sent),
    .credit_error   (cerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: occupancy is the queue size, credit is a plain integer.
  logic [8:0] mq[$];
  int         m_credit;
  bit         m_req, m_cerr;
  logic [8:0] m_rd;
  bit         m_rd_ok, m_wr_ok, m_inc, m_dec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_credit = 0;
      m_req    = 0;
      m_cerr   = 0;
      m_rd     = '0;
    end else begin
      m_rd_ok = rd && (mq.size() > 0);
      m_wr_ok = wr && (mq.size() < 64 || m_rd_ok);
      m_inc   = fct_sent && m_req;
      m_dec   = m_wr_ok && (m_credit > 0);
      if (m_rd_ok) m_rd = mq.pop_front();
      if (m_wr_ok) mq.push_back(din);
      if (!link_run) begin
        m_credit = 0;
        m_req    = 0;
        m_cerr   = 0;
      end else begin
        if (wr && m_credit == 0) m_cerr = 1;
        m_credit = m_credit + (m_inc ? 8 : 0) - (m_dec ? 1 : 0);
        m_req    = (m_credit + 8 <= 56) && (mq.size() + m_credit + 8 <= 64);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("rd_data", int'(rd_data), int'(m_rd));
    chk("empty",   int'(empty),   int'(mq.size() == 0));
    chk("full",    int'(full),    int'(mq.size() == 64));
    chk("level",   int'(level),   mq.size());
    chk("fct_req", int'(req),     int'(m_req));
    chk("cred_err", int'(cerr),   int'(m_cerr));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr1(input logic [8:0] d);
    din = d;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
  endtask

  task automatic rd1();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic fct1();
    fct_sent = 1'b1;
    tick();
    fct_sent = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_data"}, int'(rd_data), 0);
    chk({tag, "_empty"},   int'(empty),   1);
    chk({tag, "_full"},    int'(full),    0);
    chk({tag, "_level"},   int'(level),   0);
    chk({tag, "_req"},     int'(req),     0);
    chk({tag, "_cerr"},    int'(cerr),    0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk("req_link_down", int'(req), 0);

    // Credit ramp to the cap
    link_run = 1'b1;
    tick();
    chk("req_after_run", int'(req), 1);
    repeat (6) fct1();
    chk("req_credit48", int'(req), 1);
    fct1();
    chk("req_credit56", int'(req), 0);
    tick();
    chk("req_hold_off", int'(req), 0);

    // Consume 8 credits, regain one step
    for (int i = 0; i < 8; i++) wr1(9'h041 + 9'(i));
    chk("level8", int'(level), 8);
    chk("req_credit48_lvl8", int'(req), 1);
    fct1();
    chk("req_after_regrant", int'(req), 0);
    repeat (8) rd1();
    chk("drain_last", int'(rd_data), 'h048);
    chk("drain_empty", int'(empty), 1);

    // Fill with link down, overflow write dropped
    link_run = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) wr1(9'(i));
    wr1(9'h1AA);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 64);
    for (int i = 0; i < 64; i++) begin
      rd1();
      chk("fifo_order", int'(rd_data), i);
    end
    chk("after_drain_empty", int'(empty), 1);

    // Simultaneous read/write at full
    for (int i = 0; i < 64; i++) wr1(9'h100 + 9'(i));
    rd = 1'b1;
    wr1(9'h1F0);
    rd = 1'b0;
    chk("rw_full_level", int'(level), 64);
    chk("rw_full_data", int'(rd_data), 'h100);
    repeat (64) rd1();
    chk("rw_full_tail", int'(rd_data), 'h1F0);
    chk("rw_full_empty", int'(empty), 1);

    // Simultaneous read/write on empty: write only
    rd = 1'b1;
    wr1(9'h0AB);
    rd = 1'b0;
    chk("rw_empty_level", int'(level), 1);
    chk("rw_empty_hold", int'(rd_data), 'h1F0);
    rd1();
    chk("rw_empty_data", int'(rd_data), 'h0AB);

    // Write without credit
    link_run = 1'b1;
    tick();
    wr1(9'h1FF);
    chk("cerr_set", int'(cerr), 1);
    repeat (3) tick();
    chk("cerr_sticky", int'(cerr), 1);
    link_run = 1'b0;
    tick();
    chk("cerr_clear", int'(cerr), 0);
    rd1();
    chk("cerr_char_stored", int'(rd_data), 'h1FF);

    // Asynchronous reset mid-burst at level 10, credit 30
    for (int i = 0; i < 8; i++) wr1(9'h010 + 9'(i));
    link_run = 1'b1;
    tick();
    repeat (4) fct1();
    wr1(9'h020);
    wr1(9'h021);
    chk("pre_rst_level", int'(level), 10);
    chk("pre_rst_req", int'(req), 1);
    din = 9'h022;
    wr  = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    wr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("req_after_release", int'(req), 1);
    chk("level_after_release", int'(level), 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
